// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient reload path.
`timescale 1ns/1ps
package fir_pkg;

  localparam int COEF_WIDTH_DEF = 18;

  typedef logic [COEF_WIDTH_DEF-1:0] coef_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    ARM,
    FLUSH
  } fir_coef_state_e;

  function automatic logic is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Two-bank coefficient register file. Writes always land in the shadow
// bank (!bank_o); swap_i flips which bank drives coef_o.
`timescale 1ns/1ps
module fir_coef_bank #(
  parameter int COEF_WIDTH = 18,
  parameter int TAP_NUM    = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 we_i,
  input  logic [$clog2(TAP_NUM)-1:0]           addr_i,
  input  logic [COEF_WIDTH-1:0]                data_i,
  input  logic                                 swap_i,
  output logic [TAP_NUM-1:0][COEF_WIDTH-1:0]   coef_o,
  output logic                                 bank_o
);

  logic [TAP_NUM-1:0][COEF_WIDTH-1:0] bank0_q;
  logic [TAP_NUM-1:0][COEF_WIDTH-1:0] bank1_q;
  logic                               bank_q;

  // Shadow-bank write and atomic active-bank toggle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank0_q <= '0;
      bank1_q <= '0;
      bank_q  <= 1'b0;
    end else begin
      if (we_i) begin
        if (bank_q) bank0_q[addr_i] <= data_i;
        else        bank1_q[addr_i] <= data_i;
      end
      if (swap_i) bank_q <= ~bank_q;
    end
  end

  assign coef_o = bank_q ? bank1_q : bank0_q;
  assign bank_o = bank_q;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient reload controller: streams a new set into the shadow
// bank, swaps on a sample strobe and masks FIR output while the pipeline
// still holds mixed-coefficient data.
//
// Handshake: a beat transfers on the rising edge where s_tvalid_i && s_tready_o.
// s_tready_o is a decode of registered state only; s_tdata_i / s_tlast_i are
// used only on a transfer. Beats presented while s_tready_o=0 are held off.
`timescale 1ns/1ps
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int COEF_WIDTH = 18,
  parameter int TAP_NUM    = 32,
  parameter int FLUSH_LEN  = TAP_NUM + $clog2(TAP_NUM)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               s_tvalid_i,
  output logic                               s_tready_o,
  input  logic [COEF_WIDTH-1:0]              s_tdata_i,
  input  logic                               s_tlast_i,
  input  logic                               sample_tvalid_i,
  output logic [TAP_NUM-1:0][COEF_WIDTH-1:0] coef_o,
  output logic                               bank_o,
  output logic                               flush_o,
  output logic                               busy_o,
  output logic                               err_o,
  output fir_coef_state_e                    state_o
);

  localparam int AW  = $clog2(TAP_NUM);
  localparam int FCW = $clog2(FLUSH_LEN + 1);
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(TAP_NUM - 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

  if (!is_pow2(TAP_NUM) || (TAP_NUM < 2)) begin : g_bad_tap_num
    $error("fir_coef_ctrl: TAP_NUM must be a power of 2 and at least 2");
  end

  fir_coef_state_e state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic            err_q, err_d;
  logic            beat;
  logic            we;
  logic [AW-1:0]   waddr;
  logic            swap;

  assign beat = s_tvalid_i && s_tready_o;

  // State, counters and sticky error register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state, shadow write strobes and swap pulse.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;
    we          = 1'b0;
    waddr       = wr_cnt_q;
    swap        = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          we       = 1'b1;
          waddr    = '0;
          wr_cnt_d = AW'(1);
          err_d    = 1'b0;
          // A one-beat set is always short.
          if (s_tlast_i) err_d   = 1'b1;
          else           state_d = LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          we       = 1'b1;
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (s_tlast_i) begin
            if (wr_cnt_q == LAST_ADDR) begin
              state_d = ARM;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (wr_cnt_q == LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat && s_tlast_i) state_d = IDLE;
      end
      ARM: begin
        if (sample_tvalid_i) begin
          swap        = 1'b1;
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (sample_tvalid_i) begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
          if (flush_cnt_q == FLUSH_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fir_coef_bank #(
    .COEF_WIDTH (COEF_WIDTH),
    .TAP_NUM    (TAP_NUM)
  ) u_bank (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (we),
    .addr_i (waddr),
    .data_i (s_tdata_i),
    .swap_i (swap),
    .coef_o (coef_o),
    .bank_o (bank_o)
  );

  assign s_tready_o = (state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN);
  assign flush_o    = (state_q == FLUSH);
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Run-time coefficient reload controller for the multi-channel FIR filter. It accepts a new coefficient set as a stream and writes it into a shadow bank while the filter keeps running on the active bank. It swaps banks atomically on a sample strobe, then asserts a flush mask for as many samples as the filter pipeline holds mixed-coefficient data. It sits between the control/config path and the FIR datapath, driving the FIR's coefficient vector and gating its output valid.

## Interface
- COEF_WIDTH, 18, coefficient width in bits
- TAP_NUM, 32, taps per set; must be a power of 2 (elaboration `$error` otherwise)
- FLUSH_LEN, TAP_NUM + $clog2(TAP_NUM), sample strobes masked after a swap
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_tvalid_i  in  1  coefficient beat valid
- s_tready_o  out  1  coefficient beat ready
- s_tdata_i  in  COEF_WIDTH  coefficient, tap 0 first
- s_tlast_i  in  1  last beat of set
- sample_tvalid_i  in  1  FIR input sample strobe (same signal as the FIR tvalid_i)
- coef_o  out  TAP_NUM x COEF_WIDTH  active coefficient set, packed `[TAP_NUM-1:0][COEF_WIDTH-1:0]`
- bank_o  out  1  index of active bank
- flush_o  out  1  FIR output is invalid; consumer ANDs FIR tvalid_o with !flush_o
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky length error; cleared only by reset or the first beat of the next set

## Operation
- Storage: two banks of TAP_NUM x COEF_WIDTH registers. coef_o = bank[bank_o], combinational from registers. The shadow bank is always !bank_o.
- Beat accepted = s_tvalid_i && s_tready_o. wr_cnt ($clog2(TAP_NUM) bits) addresses the shadow bank.
- FSM states: IDLE, LOAD, DRAIN, ARM, FLUSH.
- IDLE: s_tready_o=1. An accepted beat writes shadow[0], sets wr_cnt=1, clears err_o, and moves to LOAD. If the beat also has s_tlast_i, set err_o and stay in IDLE; this case occurs only when TAP_NUM>1.
- LOAD: s_tready_o=1. Each accepted beat writes shadow[wr_cnt] and increments wr_cnt.
  - Beat with tlast at wr_cnt==TAP_NUM-1: go to ARM.
  - Beat with tlast at wr_cnt<TAP_NUM-1: short set. Set err_o, return to IDLE. The shadow bank contents are don't-care and are never made active.
  - Beat without tlast at wr_cnt==TAP_NUM-1: long set. Set err_o, go to DRAIN.
- DRAIN: s_tready_o=1. Beats are discarded. The beat carrying tlast returns the FSM to IDLE, and no swap occurs.
- ARM: s_tready_o=0. Wait for sample_tvalid_i=1. On that edge: toggle bank_o, set flush_o=1, clear flush_cnt, go to FLUSH.
- FLUSH: s_tready_o=0. Each sample_tvalid_i=1 increments flush_cnt. On the edge where flush_cnt reaches FLUSH_LEN, clear flush_o and go to IDLE.
- The active bank is never written.
- Gaps in s_tvalid_i or sample_tvalid_i are legal in every state; counters hold.

## Timing
- Reset values (asynchronous): state=IDLE, both banks all zeros, coef_o=0, bank_o=0, flush_o=0, err_o=0, busy_o=0, wr_cnt=0, flush_cnt=0. s_tready_o=1 in the first cycle after reset deassertion.
- s_tready_o is a registered-state decode and does not depend on s_tvalid_i.
- Swap latency: coef_o and bank_o change on the same edge as the first sample_tvalid_i seen in ARM. That same strobe's sample enters the FIR pipeline with old-coefficient history, which is why it is covered by flush_o.
- flush_o is high for exactly FLUSH_LEN sample strobes. Counting includes the strobes that fall while flush_o is already high; the swap strobe is not counted.
- Minimum set-to-swap time: TAP_NUM beat cycles plus 1 ARM cycle, provided sample_tvalid_i is already high.
- Reset mid-operation (LOAD, ARM, FLUSH): immediate return to reset values. Bank contents are lost.

## Structure
- Shared package `fir_pkg`: `fir_coef_state_e` enum (IDLE, LOAD, DRAIN, ARM, FLUSH) and the `coef_t` typedef (`logic [COEF_WIDTH-1:0]`).
- One sub-module `fir_coef_bank`: the two-bank register file. It takes write enable, address, data, a swap pulse, and async reset, and outputs coef_o and bank_o.
- The FSM and counters live in `fir_coef_ctrl`.

## Test plan
- Reset: assert rst_i mid-cycle without a clock edge -> all outputs reach reset values immediately; coef_o=0, s_tready_o=1 after release.
- Normal load (TAP_NUM=32): beats 1..32 with tlast on 32, then one sample strobe -> bank_o=1, coef_o[0]=1 and coef_o[31]=32 on the strobe edge. flush_o stays high for the next 37 strobes, then drops; busy_o=0; err_o=0.
- Short set: tlast on beat 10 -> err_o=1, bank_o=0 and coef_o unchanged, FSM in IDLE. The next full set clears err_o on its first beat and swaps normally.
- Long set: 40 beats with tlast on 40 -> err_o=1, beats 33..40 accepted and discarded, no swap, FSM in IDLE after beat 40.
- Backpressure and gaps: random s_tvalid_i gaps during LOAD; s_tvalid_i held high through ARM/FLUSH -> s_tready_o=0, no write. In ARM, sample_tvalid_i held low for 100 cycles -> no swap until the first strobe.
- Reset mid-LOAD after 16 beats -> bank_o=0, coef_o=0. A subsequent full load swaps correctly.
